// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the buffered UART transmitter.
package uart_pkg;

  // Transmit FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } uart_tx_state_t;

  // Parity modes
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Parity bit to transmit for a data byte in the given mode (0 when no parity)
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic result;
    if (mode == PARITY_ODD) begin
      result = ~(^data);
    end else if (mode == PARITY_EVEN) begin
      result = ^data;
    end else begin
      result = 1'b0;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead byte FIFO. full/empty are registered from the next count.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             wr_acc_s;
  logic             rd_acc_s;

  // Accept/pop qualification and next occupancy
  always_comb begin
    wr_acc_s     = wr_en && !full_r;
    rd_acc_s     = rd_en && !empty_r;
    count_next_s = count_r;
    if (wr_acc_s && !rd_acc_s) begin
      count_next_s = count_r + CNT_W'(1);
    end else if (rd_acc_s && !wr_acc_s) begin
      count_next_s = count_r - CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, count and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_W'(FIFO_DEPTH));
      empty_r <= (count_next_s == CNT_W'(0));
    end
  end

  // Storage array; contents need no reset since empty gates every read
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser.
module uart_tx_buffered import uart_pkg::*; #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int PARITY        = 0,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx_out
);

  localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
  // Keep at least one counter bit so a divide-by-one build still elaborates
  localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam bit HAS_PARITY = (PARITY != PARITY_NONE);

  uart_tx_state_t    state_r;
  uart_tx_state_t    state_next_s;
  logic [BAUD_W-1:0] baud_cnt_r;
  logic [BAUD_W-1:0] baud_cnt_next_s;
  logic [2:0]        bit_idx_r;
  logic [2:0]        bit_idx_next_s;
  logic [7:0]        shift_r;
  logic [7:0]        shift_next_s;
  logic              par_r;
  logic              par_next_s;
  logic              tx_r;
  logic              tx_next_s;
  logic              busy_r;
  logic              overflow_r;
  logic              baud_tick_s;
  logic              rd_en_s;
  logic [7:0]        fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .wr_en (wr_en),
    .rd_en (rd_en_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state, datapath updates and next line level
  always_comb begin
    baud_tick_s     = (baud_cnt_r == BAUD_LAST);
    state_next_s    = state_r;
    baud_cnt_next_s = baud_tick_s ? BAUD_W'(0) : (baud_cnt_r + BAUD_W'(1));
    bit_idx_next_s  = bit_idx_r;
    shift_next_s    = shift_r;
    par_next_s      = par_r;
    rd_en_s         = 1'b0;

    case (state_r)
      IDLE: begin
        baud_cnt_next_s = BAUD_W'(0);
        if (!fifo_empty_s) begin
          rd_en_s      = 1'b1;
          shift_next_s = fifo_dout_s;
          par_next_s   = parity_bit(fifo_dout_s, PARITY);
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (baud_tick_s) begin
          state_next_s   = DATA;
          bit_idx_next_s = 3'd0;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (baud_tick_s) begin
          if (bit_idx_r == 3'd7) begin
            state_next_s = HAS_PARITY ? PAR : STOP;
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
            shift_next_s   = {1'b0, shift_r[7:1]};
          end
        end else begin
          state_next_s = DATA;
        end
      end
      PAR: begin
        if (baud_tick_s) begin
          state_next_s = STOP;
        end else begin
          state_next_s = PAR;
        end
      end
      STOP: begin
        if (baud_tick_s) begin
          // Chain straight into the next frame when a byte is waiting
          if (!fifo_empty_s) begin
            rd_en_s      = 1'b1;
            shift_next_s = fifo_dout_s;
            par_next_s   = parity_bit(fifo_dout_s, PARITY);
            state_next_s = START;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s    = IDLE;
        baud_cnt_next_s = BAUD_W'(0);
      end
    endcase

    case (state_next_s)
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
      PAR:     tx_next_s = par_next_s;
      default: tx_next_s = 1'b1;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= BAUD_W'(0);
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      par_r      <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      baud_cnt_r <= baud_cnt_next_s;
      bit_idx_r  <= bit_idx_next_s;
      shift_r    <= shift_next_s;
      par_r      <= par_next_s;
      tx_r       <= tx_next_s;
      busy_r     <= (state_next_s != IDLE);
      overflow_r <= overflow_r | (wr_en & fifo_full_s);
    end
  end

  assign full     = fifo_full_s;
  assign empty    = fifo_empty_s;
  assign busy     = busy_r;
  assign overflow = overflow_r;
  assign tx_out   = tx_r;

endmodule
